// File: rtl/cpu_sram_arbiter_if.sv
// cpu_sram_arbiter_if: one sram-like request port (addr_ok/data_ok handshake).
//   master: the requester (core side) - drives req/wr/size/addr/wdata.
//   slave:  the arbiter side - drives addr_ok/data_ok/rdata.
// Signals:
//   req      request valid
//   wr       1 = write, 0 = read
//   size     0 = byte, 1 = half, 2 = word
//   addr     byte address
//   wdata    write data, lane-replicated by the requester
//   addr_ok  request accepted this cycle
//   data_ok  access complete; rdata valid
//   rdata    read data
interface cpu_sram_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/cpu_sram_arbiter.sv
// cpu_sram_arbiter: shares one synchronous SRAM between the core's instruction and
// data sram-like ports. One access is outstanding at a time; it completes after a
// fixed RAM_LATENCY cycles, and a new grant may overlap the completion cycle.
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous, active-high; forces every output to 0
//   inst       instruction request port (slave modport)
//   data       data request port (slave modport)
//   ram_en     SRAM enable (high only in a grant cycle)
//   ram_wen    SRAM byte write enables (0 for reads and misaligned writes)
//   ram_addr   word-aligned SRAM address
//   ram_wdata  SRAM write data
//   ram_rdata  SRAM read data, passed through to the owner on completion
module cpu_sram_arbiter #(
  parameter int unsigned RAM_LATENCY = 1  // legal range 1..4
) (
  input  logic                     clk,
  input  logic                     reset,
  cpu_sram_arbiter_if.slave        inst,
  cpu_sram_arbiter_if.slave        data,
  output logic                     ram_en,
  output logic [3:0]               ram_wen,
  output logic [31:0]              ram_addr,
  output logic [31:0]              ram_wdata,
  input  logic [31:0]              ram_rdata
);

  localparam logic [2:0] LatCnt = 3'(RAM_LATENCY);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       owner_q, owner_d;  // 0 = inst, 1 = data
  logic       last_q, last_d;    // port granted most recently
  logic       done;
  logic       grant;
  logic       pick_data;

  // Byte enables for an aligned write; misaligned or size 3 yields no lanes.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      2'd0:    be = 4'b0001 << off;
      2'd1:    be = off[0] ? 4'b0000 : (4'b0011 << {off[1], 1'b0});
      2'd2:    be = (off == 2'b00) ? 4'b1111 : 4'b0000;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      owner_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    owner_d       = owner_q;
    last_d        = last_q;
    inst.addr_ok  = 1'b0;
    inst.data_ok  = 1'b0;
    inst.rdata    = 32'h0;
    data.addr_ok  = 1'b0;
    data.data_ok  = 1'b0;
    data.rdata    = 32'h0;
    ram_en        = 1'b0;
    ram_wen       = 4'b0000;
    ram_addr      = 32'h0;
    ram_wdata     = 32'h0;

    done  = (state_q == StBusy) && (cnt_q == 3'd1);
    // Gating with reset keeps every output low while reset is held.
    grant = !reset && ((state_q == StIdle) || done) && (inst.req || data.req);
    // On a tie the port that did not win last time goes next.
    pick_data = data.req && (!inst.req || !last_q);

    if (state_q == StBusy) begin
      cnt_d = cnt_q - 3'd1;
      if (done) state_d = StIdle;
    end

    if (!reset && done) begin
      if (owner_q) begin
        data.data_ok = 1'b1;
        data.rdata   = ram_rdata;
      end else begin
        inst.data_ok = 1'b1;
        inst.rdata   = ram_rdata;
      end
    end

    if (grant) begin
      ram_en  = 1'b1;
      state_d = StBusy;
      cnt_d   = LatCnt;
      owner_d = pick_data;
      last_d  = pick_data;
      if (pick_data) begin
        data.addr_ok = 1'b1;
        ram_addr     = {data.addr[31:2], 2'b00};
        ram_wdata    = data.wdata;
        ram_wen      = data.wr ? byte_en(data.size, data.addr[1:0]) : 4'b0000;
      end else begin
        inst.addr_ok = 1'b1;
        ram_addr     = {inst.addr[31:2], 2'b00};
        ram_wdata    = inst.wdata;
        ram_wen      = inst.wr ? byte_en(inst.size, inst.addr[1:0]) : 4'b0000;
      end
    end
  end

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// Bench for cpu_sram_arbiter: three instances (RAM_LATENCY = 1, 2, 3) share one set of
// stimulus; a transaction-level model predicts grants and completions for each.
module tb_cpu_sram_arbiter;
  localparam int NDUT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req, i_wr, d_req, d_wr;
  logic [1:0]  i_size, d_size;
  logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
  logic [31:0] ram_rdata;

  logic        i_aok [NDUT];
  logic        i_dok [NDUT];
  logic        d_aok [NDUT];
  logic        d_dok [NDUT];
  logic        ram_en [NDUT];
  logic [31:0] i_rd [NDUT];
  logic [31:0] d_rd [NDUT];
  logic [31:0] ram_addr [NDUT];
  logic [31:0] ram_wdata [NDUT];
  logic [3:0]  ram_wen [NDUT];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    cpu_sram_arbiter_if inst_bus ();
    cpu_sram_arbiter_if data_bus ();
    assign inst_bus.req   = i_req;
    assign inst_bus.wr    = i_wr;
    assign inst_bus.size  = i_size;
    assign inst_bus.addr  = i_addr;
    assign inst_bus.wdata = i_wdata;
    assign data_bus.req   = d_req;
    assign data_bus.wr    = d_wr;
    assign data_bus.size  = d_size;
    assign data_bus.addr  = d_addr;
    assign data_bus.wdata = d_wdata;
    assign i_aok[k] = inst_bus.addr_ok;
    assign i_dok[k] = inst_bus.data_ok;
    assign i_rd[k]  = inst_bus.rdata;
    assign d_aok[k] = data_bus.addr_ok;
    assign d_dok[k] = data_bus.data_ok;
    assign d_rd[k]  = data_bus.rdata;

    cpu_sram_arbiter #(.RAM_LATENCY(k + 1)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .inst      (inst_bus),
      .data      (data_bus),
      .ram_en    (ram_en[k]),
      .ram_wen   (ram_wen[k]),
      .ram_addr  (ram_addr[k]),
      .ram_wdata (ram_wdata[k]),
      .ram_rdata (ram_rdata)
    );
  end

  // Reference model: each instance holds at most one access, due at cycle m_done.
  int          cyc = 0;
  bit          m_busy [NDUT];
  int          m_done [NDUT];
  bit          m_owner [NDUT];
  bit          m_last [NDUT];
  bit          m_cmp [NDUT];
  bit          g_valid [NDUT];
  bit          g_who [NDUT];
  bit          e_iaok [NDUT];
  bit          e_daok [NDUT];
  bit          e_idok [NDUT];
  bit          e_ddok [NDUT];
  bit          e_en [NDUT];
  logic [3:0]  e_wen [NDUT];
  logic [31:0] e_addr [NDUT];
  logic [31:0] e_wdata [NDUT];
  logic [31:0] e_ird [NDUT];
  logic [31:0] e_drd [NDUT];

  function automatic logic [3:0] exp_be(input logic [1:0] size, input logic [31:0] addr);
    int nbytes = 1 << size;
    int off = int'(addr % 4);
    if (size == 2'd3 || (off % nbytes) != 0) return 4'b0000;
    return 4'(((1 << nbytes) - 1) << off);
  endfunction

  task automatic model_eval();
    for (int k = 0; k < NDUT; k++) begin
      e_iaok[k] = 0; e_daok[k] = 0; e_idok[k] = 0; e_ddok[k] = 0; e_en[k] = 0;
      e_wen[k] = '0; e_addr[k] = '0; e_wdata[k] = '0; e_ird[k] = '0; e_drd[k] = '0;
      m_cmp[k] = 0; g_valid[k] = 0; g_who[k] = 0;
      if (!reset) begin
        m_cmp[k] = m_busy[k] && (m_done[k] == cyc);
        if (m_cmp[k]) begin
          if (m_owner[k]) begin e_ddok[k] = 1; e_drd[k] = ram_rdata; end
          else begin e_idok[k] = 1; e_ird[k] = ram_rdata; end
        end
        g_valid[k] = (!m_busy[k] || m_cmp[k]) && (i_req || d_req);
        g_who[k] = (i_req && d_req) ? !m_last[k] : d_req;
        if (g_valid[k]) begin
          e_en[k] = 1;
          if (g_who[k]) begin
            e_daok[k] = 1;
            e_addr[k] = d_addr & 32'hFFFF_FFFC;
            e_wdata[k] = d_wdata;
            e_wen[k] = d_wr ? exp_be(d_size, d_addr) : 4'b0000;
          end else begin
            e_iaok[k] = 1;
            e_addr[k] = i_addr & 32'hFFFF_FFFC;
            e_wdata[k] = i_wdata;
            e_wen[k] = i_wr ? exp_be(i_size, i_addr) : 4'b0000;
          end
        end
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic commit();
    @(posedge clk);
    for (int k = 0; k < NDUT; k++) begin
      if (reset) begin
        m_busy[k] = 0;
        m_last[k] = 0;
      end else begin
        if (m_cmp[k]) m_busy[k] = 0;
        if (g_valid[k]) begin
          m_busy[k]  = 1;
          m_done[k]  = cyc + k + 1;
          m_owner[k] = g_who[k];
          m_last[k]  = g_who[k];
        end
      end
    end
    cyc++;
    #1;
    ram_rdata = $urandom;
  endtask

  task automatic drive_idle();
    i_req = 0; i_wr = 0; i_size = 2'd2; i_addr = '0; i_wdata = '0;
    d_req = 0; d_wr = 0; d_size = 2'd2; d_addr = '0; d_wdata = '0;
  endtask

  task automatic idle(input int n);
    drive_idle();
    for (int i = 0; i < n; i++) begin settle(); commit(); end
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1;
    settle(); commit();
    reset = 0;
  endtask

  task automatic test_reset();
    drive_idle();
    i_req = 1; d_req = 1;
    reset = 1;
    settle();
    for (int k = 0; k < NDUT; k++) begin
      checks++;
      if ({i_aok[k], d_aok[k], i_dok[k], d_dok[k], ram_en[k]} !== 5'b0) begin
        errors++;
        $display("FAIL reset_ctl[%0d]: got %b expected 00000", k,
                 {i_aok[k], d_aok[k], i_dok[k], d_dok[k], ram_en[k]});
      end
      checks++;
      if ({ram_wen[k], ram_addr[k], ram_wdata[k], i_rd[k], d_rd[k]} !== '0) begin
        errors++;
        $display("FAIL reset_data[%0d]: got wen=%h addr=%h wdata=%h ird=%h drd=%h expected 0",
                 k, ram_wen[k], ram_addr[k], ram_wdata[k], i_rd[k], d_rd[k]);
      end
    end
    commit();
    reset = 0;
    drive_idle();
  endtask

  task automatic test_single_read();
    do_reset();
    i_req = 1; i_addr = 32'hBFC0_0004;
    settle();
    checks++;
    if (i_aok[0] !== 1'b1 || ram_en[0] !== 1'b1 || ram_addr[0] !== 32'hBFC0_0004) begin
      errors++;
      $display("FAIL single_grant: got aok=%b en=%b addr=%h expected 1 1 bfc00004",
               i_aok[0], ram_en[0], ram_addr[0]);
    end
    commit();
    settle();
    checks++;
    if (i_dok[0] !== 1'b1 || i_rd[0] !== ram_rdata) begin
      errors++;
      $display("FAIL single_data: got dok=%b rdata=%h expected 1 %h", i_dok[0], i_rd[0], ram_rdata);
    end
    commit();
    idle(4);
  endtask

  task automatic test_contention();
    bit prev_data = 0;
    do_reset();
    i_req = 1; i_addr = 32'h0000_1000;
    d_req = 1; d_addr = 32'h0000_2000;
    for (int c = 0; c <= 4; c++) begin
      bit want_data = (c % 2) == 0;
      if (c == 4) drive_idle();
      settle();
      if (c < 4) begin
        checks++;
        if (d_aok[0] !== want_data || i_aok[0] !== !want_data) begin
          errors++;
          $display("FAIL contend_grant c%0d: got d=%b i=%b expected d=%b i=%b",
                   c, d_aok[0], i_aok[0], want_data, !want_data);
        end
      end
      if (c > 0) begin
        checks++;
        if (d_dok[0] !== prev_data || i_dok[0] !== !prev_data ||
            (prev_data ? d_rd[0] : i_rd[0]) !== ram_rdata) begin
          errors++;
          $display("FAIL contend_done c%0d: got d=%b i=%b expected d=%b i=%b",
                   c, d_dok[0], i_dok[0], prev_data, !prev_data);
        end
      end
      prev_data = want_data;
      commit();
    end
    idle(4);
  endtask

  task automatic test_byte_enable();
    logic [1:0]  sz  [4] = '{2'd0, 2'd1, 2'd2, 2'd2};
    logic [31:0] ad  [4] = '{32'h1000_0003, 32'h1000_0002, 32'h1000_0000, 32'h1000_0001};
    logic [3:0]  exp [4] = '{4'b1000, 4'b1100, 4'b1111, 4'b0000};
    for (int t = 0; t < 4; t++) begin
      do_reset();
      d_req = 1; d_wr = 1; d_size = sz[t]; d_addr = ad[t]; d_wdata = $urandom;
      settle();
      checks++;
      if (ram_wen[0] !== exp[t] || ram_wdata[0] !== d_wdata || d_aok[0] !== 1'b1) begin
        errors++;
        $display("FAIL byte_en t%0d: got wen=%b wdata=%h aok=%b expected %b %h 1",
                 t, ram_wen[0], ram_wdata[0], d_aok[0], exp[t], d_wdata);
      end
      commit();
      drive_idle();
      settle();
      checks++;
      if (d_dok[0] !== 1'b1) begin
        errors++;
        $display("FAIL byte_en_done t%0d: got %b expected 1", t, d_dok[0]);
      end
      commit();
      idle(3);
    end
  endtask

  task automatic test_latency3();
    do_reset();
    i_req = 1; i_addr = 32'h0040_0010;
    for (int c = 0; c <= 9; c++) begin
      bit ea = (c == 0) || (c == 3) || (c == 6);
      bit ed = (c == 3) || (c == 6) || (c == 9);
      if (c == 7) i_req = 0;
      settle();
      checks++;
      if (i_aok[2] !== ea || i_dok[2] !== ed) begin
        errors++;
        $display("FAIL lat3 c%0d: got aok=%b dok=%b expected %b %b", c, i_aok[2], i_dok[2], ea, ed);
      end
      if (c == 1 || c == 2) begin
        checks++;
        if (ram_en[2] !== 1'b0) begin
          errors++;
          $display("FAIL lat3_en c%0d: got %b expected 0", c, ram_en[2]);
        end
      end
      commit();
    end
    idle(4);
  endtask

  task automatic test_reset_mid();
    do_reset();
    d_req = 1; d_addr = 32'h0000_0040;
    settle();
    checks++;
    if (d_aok[1] !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_grant: got %b expected 1", d_aok[1]);
    end
    commit();
    d_req = 0;
    reset = 1;
    settle();
    checks++;
    if ({d_aok[1], d_dok[1], i_dok[1], ram_en[1], ram_wen[1], ram_addr[1], d_rd[1]} !== '0) begin
      errors++;
      $display("FAIL rstmid_zero: got aok=%b dok=%b en=%b addr=%h expected 0",
               d_aok[1], d_dok[1], ram_en[1], ram_addr[1]);
    end
    commit();
    reset = 0;
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++;
      if (d_dok[1] !== 1'b0 || i_dok[1] !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_nodok c%0d: got d=%b i=%b expected 0 0", c, d_dok[1], i_dok[1]);
      end
      commit();
    end
    i_req = 1; i_addr = 32'h0000_0080;
    settle();
    checks++;
    if (i_aok[1] !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_regrant: got %b expected 1", i_aok[1]);
    end
    commit();
    idle(4);
  endtask

  task automatic test_withdrawal();
    do_reset();
    i_req = 1; i_addr = 32'h0000_0100;
    settle(); commit();
    i_req = 0;
    settle(); commit();
    i_req = 1; i_addr = 32'h0000_0200;
    settle();
    checks++;
    if (i_aok[2] !== 1'b0 || ram_en[2] !== 1'b0) begin
      errors++;
      $display("FAIL withdraw_busy: got aok=%b en=%b expected 0 0", i_aok[2], ram_en[2]);
    end
    commit();
    i_req = 0;
    settle();
    checks++;
    if (i_dok[2] !== 1'b1 || i_aok[2] !== 1'b0 || ram_en[2] !== 1'b0) begin
      errors++;
      $display("FAIL withdraw_done: got dok=%b aok=%b en=%b expected 1 0 0",
               i_dok[2], i_aok[2], ram_en[2]);
    end
    commit();
    settle();
    checks++;
    if (i_dok[2] !== 1'b0 || ram_en[2] !== 1'b0) begin
      errors++;
      $display("FAIL withdraw_after: got dok=%b en=%b expected 0 0", i_dok[2], ram_en[2]);
    end
    commit();
    d_req = 1; d_addr = 32'h0000_0300;
    settle();
    checks++;
    if (d_aok[2] !== 1'b1) begin
      errors++;
      $display("FAIL withdraw_idle: got %b expected 1", d_aok[2]);
    end
    commit();
    idle(4);
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 800; n++) begin
      reset   = ($urandom_range(0, 59) == 0);
      i_req   = ($urandom_range(0, 2) != 0);
      i_wr    = $urandom_range(0, 1);
      i_size  = 2'($urandom_range(0, 3));
      i_addr  = $urandom;
      i_wdata = $urandom;
      d_req   = ($urandom_range(0, 2) != 0);
      d_wr    = $urandom_range(0, 1);
      d_size  = 2'($urandom_range(0, 3));
      d_addr  = $urandom;
      d_wdata = $urandom;
      settle();
      for (int k = 0; k < NDUT; k++) begin
        checks++;
        if ({i_aok[k], d_aok[k], i_dok[k], d_dok[k], ram_en[k]} !==
            {e_iaok[k], e_daok[k], e_idok[k], e_ddok[k], e_en[k]}) begin
          errors++;
          $display("FAIL rand_ctl[%0d] n%0d: got %b expected %b", k, n,
                   {i_aok[k], d_aok[k], i_dok[k], d_dok[k], ram_en[k]},
                   {e_iaok[k], e_daok[k], e_idok[k], e_ddok[k], e_en[k]});
        end
        checks++;
        if (i_rd[k] !== e_ird[k] || d_rd[k] !== e_drd[k]) begin
          errors++;
          $display("FAIL rand_rdata[%0d] n%0d: got %h/%h expected %h/%h", k, n,
                   i_rd[k], d_rd[k], e_ird[k], e_drd[k]);
        end
        if (e_en[k] || reset) begin
          checks++;
          if (ram_wen[k] !== e_wen[k] || ram_addr[k] !== e_addr[k] ||
              ram_wdata[k] !== e_wdata[k]) begin
            errors++;
            $display("FAIL rand_ram[%0d] n%0d: got %b %h %h expected %b %h %h", k, n,
                     ram_wen[k], ram_addr[k], ram_wdata[k], e_wen[k], e_addr[k], e_wdata[k]);
          end
        end
      end
      commit();
    end
    reset = 0;
    idle(4);
  endtask

  initial begin
    drive_idle();
    ram_rdata = $urandom;
    test_reset();
    test_single_read();
    test_contention();
    test_byte_enable();
    test_latency3();
    test_reset_mid();
    test_withdrawal();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_sram_arbiter.md
# cpu_sram_arbiter

Single-port memory arbiter between the core's instruction and data request ports and one shared synchronous SRAM. Sits directly downstream of `mycpu_top`, in place of its separate inst/data SRAMs. Accepts sram-like requests with an addr_ok/data_ok handshake, arbitrates between the two ports, and generates byte enables. Tracks exactly one outstanding access through a fixed SRAM read latency.

## Interface

**Parameters**
- `RAM_LATENCY`, default 1: cycles from SRAM enable to valid `ram_rdata`. Legal range 1–4.

**Ports** (x = `inst` / `data`; both port sets are identical)
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `x_req`  in  1  request valid.
- `x_wr`  in  1  1 = write, 0 = read.
- `x_size`  in  2  0 = byte, 1 = half, 2 = word.
- `x_addr`  in  32  byte address.
- `x_wdata`  in  32  write data, already lane-replicated by the core.
- `x_addr_ok`  out  1  request accepted this cycle.
- `x_data_ok`  out  1  access complete; read data valid.
- `x_rdata`  out  32  read data.
- `ram_en`  out  1  SRAM enable.
- `ram_wen`  out  4  SRAM byte write enables.
- `ram_addr`  out  32  word address: `{addr[31:2], 2'b00}`.
- `ram_wdata`  out  32  write data.
- `ram_rdata`  in  32  SRAM read data.

## Operation

**State**
- `state`: IDLE or BUSY.
- `cnt`: 3-bit latency counter.
- `owner`: port that owns the outstanding access (0 = inst, 1 = data).
- `last`: port granted most recently.

**Arbitration (IDLE, or the completion cycle of BUSY)**
- If only one port requests, grant it.
- If both request, grant the port ≠ `last`.
- `last` resets to inst, so data wins the first tie.

**Grant cycle**
- Winner's `x_addr_ok` = 1 (combinational); the loser's `x_addr_ok` = 0.
- `ram_en` = 1; `ram_addr`, `ram_wdata` and `ram_wen` are taken from the winner.
- Update `owner` and `last`; `cnt` ← `RAM_LATENCY`; `state` ← BUSY.

**Byte enables (writes only; reads drive `ram_wen` = 0)**
- size 0: `4'b0001 << addr[1:0]`.
- size 1: `4'b0011 << {addr[1], 1'b0}`.
- size 2: `4'b1111`.
- Misaligned (size 1 with addr[0] = 1, size 2 with addr[1:0] ≠ 0) or size 3: `ram_wen` = 0.
- Reads in these cases still execute and complete normally, because the core reports AdEL/AdES itself.

**BUSY**
- `cnt` decrements each cycle.
- When `cnt` = 1 (completion cycle):
  - `owner`'s `x_data_ok` = 1.
  - `x_rdata` = `ram_rdata`, combinational pass-through.
  - The same cycle may grant a new request: stay BUSY and reload `cnt`. With no request, go to IDLE.
- Outside the completion cycle, no `addr_ok` is asserted and `ram_en` = 0.

**Other rules**
- Non-owner `x_rdata` = 0; owner `x_rdata` = 0 outside the `data_ok` cycle.
- Writes also return `data_ok`, with the same latency as reads.
- A request deasserted before `addr_ok` is simply not granted; there is no requirement to hold it.

## Timing

- **Reset:**
  - While `reset` is high, all outputs are 0.
  - `state` = IDLE, `cnt` = 0, `owner` = 0, `last` = inst.
  - An outstanding access is dropped; no `data_ok` is issued for it.
  - The first grant is possible in the first cycle after `reset` falls.
- **Latency:** grant in cycle T → `data_ok` in cycle T + `RAM_LATENCY`.
- **Throughput:**
  - `RAM_LATENCY` = 1: one access per cycle, since the completion cycle and the next grant overlap.
  - Otherwise: one access per `RAM_LATENCY` cycles.
- **Contention:** requests held continuously on both ports are granted alternately: data, inst, data, …
- **Same-port re-grant:** a port's `data_ok` and a new `addr_ok` for that same port may coincide in one cycle.
- **Single-request rule:** at most one `addr_ok` and at most one `data_ok` is high in any cycle.

## Test plan

1. **Single read, `RAM_LATENCY` = 1.** Hold `inst_req` with addr `0xBFC0_0004`.
   - Required: `inst_addr_ok` = 1 and `ram_addr` = `0xBFC0_0004` in cycle T.
   - Required: `inst_data_ok` = 1 with `inst_rdata` = `ram_rdata` in T+1.
2. **Contention.** Hold both `inst_req` and `data_req` (read) for 4 cycles after reset.
   - Required: grant order data, inst, data, inst.
   - Required: each `data_ok` goes to the matching port one cycle after its grant.
3. **Byte-enable sweep.** Data writes:
   - size 0, addr `0x…3` → `ram_wen` = `1000`.
   - size 1, addr `0x…2` → `1100`.
   - size 2, addr `0x…0` → `1111`.
   - size 2, addr `0x…1` → `0000`, and `data_data_ok` still asserts.
4. **`RAM_LATENCY` = 3.** Issue back-to-back inst reads.
   - Required: `addr_ok` at T, T+3, T+6; `data_ok` at T+3, T+6, T+9.
   - Required: `ram_en` low in T+1, T+2.
5. **Reset mid-access.** Assert `reset` one cycle after a grant with `RAM_LATENCY` = 2.
   - Required: all outputs immediately 0; no `data_ok` afterwards.
   - Required: the next request after reset is granted in its first cycle.
6. **Request withdrawal.** Raise `inst_req` during BUSY, then drop it before completion.
   - Required: no grant and no `ram_en` for it; `state` returns to IDLE.
